press_classifier: RTL and testbench
===================================

PRESS_CLASSIFIER -- requirements
Module: press_classifier

Interface
REQ-001 Parameter LONG_CYCLES, default 50000: consecutive high samples of buttonStable that make a long press; the legal range is 2 to 65535.
REQ-002 Parameter GAP_CYCLES, default 15000: consecutive low samples after a short release that close the double-press window; the legal range is 2 to 65535.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 buttonStable  input  1  debounced, clk-synchronous button level from the upstream debouncer; high = pressed.
REQ-006 shortPress  output  1  one-cycle pulse: single press released before LONG_CYCLES, no second press within the gap.
REQ-007 longPress  output  1  one-cycle pulse: press held for LONG_CYCLES samples.
REQ-008 doublePress  output  1  one-cycle pulse: second press started inside the gap window, then released.
REQ-009 held  output  1  level, high while in state LONG_HELD.

Function
REQ-010 The block SHALL implement a five-state FSM: IDLE, PRESSED, WAIT_GAP, SECOND, LONG_HELD; it has one 16-bit counter `cnt`.
REQ-011 All outputs SHALL be registered; each pulse is high for exactly one clk cycle, starting on the same edge as the FSM transition that produces it.
REQ-012 IDLE: buttonStable=1 -> PRESSED, cnt<=1; otherwise stay, cnt<=0.
REQ-013 PRESSED, buttonStable=1, cnt==LONG_CYCLES-1: the block SHALL pulse longPress and go to LONG_HELD. Otherwise it SHALL do cnt<=cnt+1. The pulse therefore occurs on the LONG_CYCLES-th consecutive high sample.
REQ-014 PRESSED, buttonStable=0 -> WAIT_GAP, cnt<=1.
REQ-015 WAIT_GAP, buttonStable=1 -> SECOND, cnt<=0.
REQ-016 WAIT_GAP, buttonStable=0, cnt==GAP_CYCLES-1: the block SHALL pulse shortPress and go to IDLE. Otherwise it SHALL do cnt<=cnt+1. The pulse therefore occurs on the GAP_CYCLES-th consecutive low sample.
REQ-017 SECOND: the block SHALL wait for buttonStable=0, then pulse doublePress and go to IDLE. Second-press duration is ignored: no longPress is issued from SECOND, and cnt holds.
REQ-018 LONG_HELD: held=1. buttonStable=0 -> IDLE with held<=0 on that edge. No pulses are issued from this state.
REQ-019 cnt SHALL never exceed max(LONG_CYCLES, GAP_CYCLES)-1 and SHALL never wrap.
REQ-020 At most one of shortPress, longPress and doublePress SHALL be high in any cycle.
REQ-021 Each physical press sequence SHALL yield exactly one pulse (short, long or double).
REQ-022 A new press arriving on the same edge that returns the FSM to IDLE is not seen until the next edge. The IDLE rule then applies.

Reset
REQ-023 While reset=1, the block SHALL asynchronously force state=IDLE, cnt=0, and shortPress=longPress=doublePress=held=0, regardless of clk.
REQ-024 Reset asserted mid-operation in any state SHALL abandon the sequence with no pulse. After deassertion a button still held high SHALL be treated as a new press from IDLE.
REQ-025 Deassertion SHALL be synchronous-safe: the first transition evaluates on the first rising clk edge after reset falls.

Verification (LONG_CYCLES=8, GAP_CYCLES=4)
REQ-026 buttonStable high for 3 cycles, then low -> shortPress single pulse on the 4th low sample; no other pulses.
REQ-027 buttonStable high for 12 cycles -> longPress pulse on the 8th high sample; held=1 from that edge until the edge after release; no shortPress.
REQ-028 High 3, low 2, high 5, low -> doublePress pulse on the first low sample after the second press; no shortPress or longPress.
REQ-029 High 3, low exactly 4, high 2 -> shortPress on the 4th low sample, then the second press is handled as a new press; its own shortPress follows after 4 lows.
REQ-030 High 7 (one short of long), low 1, reset pulse asynchronously between clk edges, button high 8 -> all outputs 0 immediately on reset; then one longPress on the 8th post-reset high sample.
REQ-031 Random press stream of 2000 cycles -> a scoreboard checks REQ-020 and REQ-021, and a cycle-exact reference model matches every pulse.

Source files
------------

// File: rtl/press_classifier_if.sv
// press_classifier_if -- button-level input and classified press outputs.
//   buttonStable : debounced, clk-synchronous button level (high = pressed)
//   shortPress   : one-cycle pulse, single press released early, no second press
//   longPress    : one-cycle pulse, press held for LONG_CYCLES samples
//   doublePress  : one-cycle pulse, second press inside the gap, then released
//   held         : level, high while a long press is still held
// master = button source / consumer of events, slave = classifier.
interface press_classifier_if;
  logic buttonStable;
  logic shortPress;
  logic longPress;
  logic doublePress;
  logic held;

  modport master (
    output buttonStable,
    input  shortPress, longPress, doublePress, held
  );

  modport slave (
    input  buttonStable,
    output shortPress, longPress, doublePress, held
  );
endinterface

// File: rtl/press_classifier.sv
// press_classifier -- classifies a debounced button level into short, long
// and double presses.
//   clk   : single clock, rising edge
//   reset : asynchronous, active-high
//   bus   : press_classifier_if.slave (buttonStable in, pulses + held out)
// One 16-bit counter is shared: it counts high samples while PRESSED and
// low samples while WAIT_GAP. All outputs are registered and change on the
// same edge as the FSM transition that produces them.
module press_classifier #(
  parameter int LONG_CYCLES = 50000,  // 2..65535
  parameter int GAP_CYCLES  = 15000   // 2..65535
) (
  input  logic               clk,
  input  logic               reset,
  press_classifier_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE,
    PRESSED,
    WAIT_GAP,
    SECOND,
    LONG_HELD
  } state_t;

  localparam logic [15:0] LONG_LAST = 16'(LONG_CYCLES - 1);
  localparam logic [15:0] GAP_LAST  = 16'(GAP_CYCLES - 1);

  state_t      state;
  logic [15:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      cnt             <= '0;
      bus.shortPress  <= 1'b0;
      bus.longPress   <= 1'b0;
      bus.doublePress <= 1'b0;
      bus.held        <= 1'b0;
    end else begin
      // pulses last one cycle unless re-asserted below
      bus.shortPress  <= 1'b0;
      bus.longPress   <= 1'b0;
      bus.doublePress <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.buttonStable) begin
            state <= PRESSED;
            cnt   <= 16'd1;
          end else begin
            cnt   <= '0;
          end
        end
        PRESSED: begin
          if (!bus.buttonStable) begin
            state <= WAIT_GAP;
            cnt   <= 16'd1;          // the release sample is the first low
          end else if (cnt == LONG_LAST) begin
            state         <= LONG_HELD;
            bus.longPress <= 1'b1;
            bus.held      <= 1'b1;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        WAIT_GAP: begin
          if (bus.buttonStable) begin
            state <= SECOND;
            cnt   <= '0;
          end else if (cnt == GAP_LAST) begin
            state          <= IDLE;
            cnt            <= '0;
            bus.shortPress <= 1'b1;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        SECOND: begin
          // duration of the second press is irrelevant; cnt holds
          if (!bus.buttonStable) begin
            state           <= IDLE;
            bus.doublePress <= 1'b1;
          end
        end
        LONG_HELD: begin
          if (!bus.buttonStable) begin
            state    <= IDLE;
            bus.held <= 1'b0;
          end
        end
        default: begin
          state    <= IDLE;
          cnt      <= '0;
          bus.held <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_press_classifier.sv
// tb_press_classifier -- directed scenarios plus a random press stream for
// press_classifier (LONG_CYCLES=8, GAP_CYCLES=4). An independent run-length
// reference model pushes expected pulses into a queue as stimulus is driven;
// a negedge monitor pops and compares them when the DUT pulses.
module tb_press_classifier;
  localparam int LC = 8;
  localparam int GC = 4;

  logic clk;
  logic reset;
  press_classifier_if bus ();

  press_classifier #(.LONG_CYCLES(LC), .GAP_CYCLES(GC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int       cyc;
    logic [2:0] kind;   // {double, long, short}
  } exp_t;

  exp_t q[$];
  int   compared = 0;
  int   mism     = 0;
  int   cyc      = 0;

  // reference model state (counts runs of samples, not a copy of the FSM)
  int   phase = 0;      // 0 idle, 1 first press, 2 gap, 3 second press, 4 long held
  int   run   = 0;
  bit   exp_held = 1'b0;
  int   seq_cnt  = 0;

  // monitor bookkeeping
  int   n_s = 0, n_l = 0, n_d = 0;
  int   last_s = -1, last_l = -1, last_d = -1;

  task automatic model_step(input logic b);
    logic [2:0] k;
    k = 3'b000;
    case (phase)
      0: if (b) begin phase = 1; run = 1; seq_cnt++; end
      1: if (b) begin
           run++;
           if (run == LC) begin k = 3'b010; phase = 4; end
         end else begin
           phase = 2; run = 1;
         end
      2: if (b) begin
           phase = 3;
         end else begin
           run++;
           if (run == GC) begin k = 3'b001; phase = 0; end
         end
      3: if (!b) begin k = 3'b100; phase = 0; end
      4: if (!b) phase = 0;
      default: phase = 0;
    endcase
    exp_held = (phase == 4);
    if (k != 3'b000) q.push_back('{cyc: cyc, kind: k});
  endtask

  task automatic model_reset();
    phase = 0; run = 0; exp_held = 1'b0;
    q.delete();
  endtask

  // drive one sample, let the edge happen, return just after the monitor
  task automatic tick(input logic b);
    bus.buttonStable = b;
    @(posedge clk);
    cyc++;
    model_step(b);
    @(negedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    logic [2:0] k;
    exp_t e;
    if (!reset) begin
      k = {bus.doublePress, bus.longPress, bus.shortPress};
      if (k != 3'b000) begin
        if (k[0]) begin n_s++; last_s = cyc; end
        if (k[1]) begin n_l++; last_l = cyc; end
        if (k[2]) begin n_d++; last_d = cyc; end
        compared++;
        if ($countones(k) != 1) begin
          mism++;
          $display("FAIL onehot cyc=%0d pulses=%b required one-hot", cyc, k);
        end
        if (q.size() == 0) begin
          mism++;
          $display("FAIL unexpected_pulse cyc=%0d got=%b required none", cyc, k);
        end else begin
          e = q.pop_front();
          compared++;
          if (e.cyc !== cyc || e.kind !== k) begin
            mism++;
            $display("FAIL pulse cyc=%0d kind=%b required cyc=%0d kind=%b", cyc, k, e.cyc, e.kind);
          end
        end
      end
      while (q.size() > 0 && q[0].cyc < cyc) begin
        e = q.pop_front();
        mism++;
        $display("FAIL missing_pulse kind=%b required at cyc=%0d not observed", e.kind, e.cyc);
      end
      compared++;
      if (bus.held !== exp_held) begin
        mism++;
        $display("FAIL held cyc=%0d got=%b required=%b", cyc, bus.held, exp_held);
      end
    end
  end

  task automatic idle_lows(input int n);
    for (int i = 0; i < n; i++) tick(1'b0);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.buttonStable = 1'b1;
    #2;
    compared++;
    if ({bus.shortPress, bus.longPress, bus.doublePress, bus.held} !== 4'b0000) begin
      mism++;
      $display("FAIL reset_state got=%b required=0000",
               {bus.shortPress, bus.longPress, bus.doublePress, bus.held});
    end
    repeat (10) @(posedge clk);   // clocks with button high must not move anything
    @(negedge clk); #1;
    compared++;
    if ({bus.shortPress, bus.longPress, bus.doublePress, bus.held} !== 4'b0000) begin
      mism++;
      $display("FAIL reset_hold got=%b required=0000",
               {bus.shortPress, bus.longPress, bus.doublePress, bus.held});
    end
    bus.buttonStable = 1'b0;
    reset = 1'b0;
    model_reset();
    idle_lows(3);
  endtask

  task automatic test_short();
    int base, s0, l0, d0;
    base = cyc; s0 = n_s; l0 = n_l; d0 = n_d;
    repeat (3) tick(1'b1);
    idle_lows(6);
    compared++;
    if (n_s - s0 !== 1 || last_s !== base + 7 || n_l !== l0 || n_d !== d0) begin
      mism++;
      $display("FAIL short shorts=%0d at=%0d longs=%0d doubles=%0d required 1 at %0d, 0, 0",
               n_s - s0, last_s, n_l - l0, n_d - d0, base + 7);
    end
  endtask

  task automatic test_long();
    int base, s0, l0;
    base = cyc; s0 = n_s; l0 = n_l;
    for (int i = 1; i <= 12; i++) begin
      tick(1'b1);
      if (i == 7 || i == 8 || i == 12) begin
        compared++;
        if (bus.held !== (i >= 8)) begin
          mism++;
          $display("FAIL long_held sample=%0d got=%b required=%b", i, bus.held, (i >= 8));
        end
      end
    end
    tick(1'b0);
    compared++;
    if (bus.held !== 1'b0) begin
      mism++;
      $display("FAIL long_release got held=%b required=0", bus.held);
    end
    idle_lows(6);
    compared++;
    if (n_l - l0 !== 1 || last_l !== base + 8 || n_s !== s0) begin
      mism++;
      $display("FAIL long longs=%0d at=%0d shorts=%0d required 1 at %0d, 0",
               n_l - l0, last_l, n_s - s0, base + 8);
    end
  endtask

  task automatic test_double();
    int base, s0, l0, d0;
    base = cyc; s0 = n_s; l0 = n_l; d0 = n_d;
    repeat (3) tick(1'b1);
    repeat (2) tick(1'b0);
    repeat (5) tick(1'b1);
    idle_lows(6);
    compared++;
    if (n_d - d0 !== 1 || last_d !== base + 11 || n_s !== s0 || n_l !== l0) begin
      mism++;
      $display("FAIL double doubles=%0d at=%0d shorts=%0d longs=%0d required 1 at %0d, 0, 0",
               n_d - d0, last_d, n_s - s0, n_l - l0, base + 11);
    end
  endtask

  task automatic test_gap_boundary();
    int base, s0, d0, first_s;
    base = cyc; s0 = n_s; d0 = n_d;
    repeat (3) tick(1'b1);
    repeat (4) tick(1'b0);
    first_s = last_s;
    repeat (2) tick(1'b1);
    idle_lows(6);
    compared++;
    if (n_s - s0 !== 2 || first_s !== base + 7 || last_s !== base + 13 || n_d !== d0) begin
      mism++;
      $display("FAIL gap_boundary shorts=%0d first=%0d second=%0d doubles=%0d required 2 at %0d,%0d, 0",
               n_s - s0, first_s, last_s, n_d - d0, base + 7, base + 13);
    end
  endtask

  task automatic test_reset_mid();
    int base, s0, l0;
    s0 = n_s; l0 = n_l;
    // seven highs and one low, then the reset lands between edges
    repeat (7) tick(1'b1);
    tick(1'b0);
    bus.buttonStable = 1'b1;
    reset = 1'b1;
    #1;
    compared++;
    if ({bus.shortPress, bus.longPress, bus.doublePress, bus.held} !== 4'b0000) begin
      mism++;
      $display("FAIL reset_mid_gap got=%b required=0000",
               {bus.shortPress, bus.longPress, bus.doublePress, bus.held});
    end
    #2 reset = 1'b0;
    model_reset();
    base = cyc;
    repeat (8) tick(1'b1);
    compared++;
    if (n_l - l0 !== 1 || last_l !== base + 8 || n_s !== s0 || bus.held !== 1'b1) begin
      mism++;
      $display("FAIL reset_mid_long longs=%0d at=%0d shorts=%0d held=%b required 1 at %0d, 0, 1",
               n_l - l0, last_l, n_s - s0, bus.held, base + 8);
    end
    // reset while long-held, button stays high: held drops at once, then new press
    reset = 1'b1;
    #1;
    compared++;
    if (bus.held !== 1'b0) begin
      mism++;
      $display("FAIL reset_held got=%b required=0", bus.held);
    end
    #2 reset = 1'b0;
    model_reset();
    base = cyc;
    repeat (8) tick(1'b1);
    compared++;
    if (n_l - l0 !== 2 || last_l !== base + 8) begin
      mism++;
      $display("FAIL reset_repress longs=%0d at=%0d required 2 at %0d", n_l - l0, last_l, base + 8);
    end
    idle_lows(6);
  endtask

  task automatic test_random();
    int p0, s0, t0, hi, lo;
    p0 = n_s + n_l + n_d;
    s0 = seq_cnt;
    t0 = cyc;
    while (cyc - t0 < 2000) begin
      hi = $urandom_range(1, 11);
      lo = $urandom_range(1, 6);
      repeat (hi) tick(1'b1);
      repeat (lo) tick(1'b0);
    end
    idle_lows(8);
    compared++;
    if (q.size() != 0) begin
      mism++;
      $display("FAIL random_queue left=%0d required=0", q.size());
    end
    compared++;
    if ((n_s + n_l + n_d) - p0 !== seq_cnt - s0) begin
      mism++;
      $display("FAIL random_pulses_per_seq pulses=%0d required=%0d",
               (n_s + n_l + n_d) - p0, seq_cnt - s0);
    end
  endtask

  initial begin
    bus.buttonStable = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    test_reset();
    test_short();
    test_long();
    test_double();
    test_gap_boundary();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
    $finish;
  end
endmodule
